uart_rx_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_rx_ctrl_if.sv | 13 +
 rtl/rx_byte_fifo.sv | 39 +++
 rtl/uart_rx_ctrl.sv | 95 +++++++++
 tb/tb_uart_rx_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive controller.
// Holds the controller FSM state type, the bytes-per-word constant and the baud divider T.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, GATHER, DONE} rx_ctrl_state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int T = 868;
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: receiver byte strobe plus core read request/ack bus.
// rx_data/rx_valid: byte from the receiver; req/req_word: core read request;
// ack/data: completion pulse and read result. master = receiver/core side, slave = controller.
interface uart_rx_ctrl_if;
  logic [7:0] rx_data;
  logic rx_valid;
  logic req;
  logic req_word;
  logic ack;
  logic [31:0] data;
  modport master(output rx_data, rx_valid, req, req_word, input ack, data);
  modport slave(input rx_data, rx_valid, req, req_word, output ack, data);
endinterface

// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: DEPTH x 8 synchronous byte FIFO.
// Ports: CLK, RST_N (async active-low), push/din write side, pop/dout read side,
// level (bytes held), full, empty. Read is first-word-fall-through off the registered array.
module rx_byte_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, push};
    rd_d = rd_q + {{AW{1'b0}}, pop};
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge CLK)
    if (push) mem[wr_q[AW-1:0]] <= din;
  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign level = wr_q - rd_q;
  assign full  = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign dout  = mem[rd_q[AW-1:0]];
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: buffers received bytes and serves 8/32-bit core reads (big-endian word assembly).
// Ports: CLK, RST_N (async active-low), bus (uart_rx_ctrl_if.slave: rx byte in, req/ack/data),
// ovr_clr (clears overrun), level (FIFO fill), overrun (sticky drop flag),
// rx_count/drop_count (statistics, built only when UART_RX_STATS_EN is defined, else 0).
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            CLK,
  input  logic            RST_N,
  uart_rx_ctrl_if.slave   bus,
  input  logic            ovr_clr,
  output logic [AW:0]     level,
  output logic            overrun,
  output logic [15:0]     rx_count,
  output logic [15:0]     drop_count
);
  rx_ctrl_state_t state_q, state_d;
  logic [2:0] need_q, need_d;
  logic [31:0] asm_q, asm_d, data_q, data_d;
  logic overrun_q, overrun_d;
  logic [7:0] dout;
  logic full, empty, push, pop, drop;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign pop  = state_q == GATHER && !empty;
  assign push = bus.rx_valid && (!full || pop);
  assign drop = bus.rx_valid && !push;
  rx_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK(CLK), .RST_N(RST_N), .push(push), .pop(pop), .din(bus.rx_data),
    .dout(dout), .level(level), .full(full), .empty(empty)
  );
  always_comb begin
    state_d   = state_q;
    need_d    = need_q;
    asm_d     = asm_q;
    data_d    = data_q;
    overrun_d = drop | (overrun_q & ~ovr_clr);
    case (state_q)
      IDLE: if (bus.req) begin
        state_d = GATHER;
        need_d  = bus.req_word ? 3'(BYTES_PER_WORD) : 3'd1;
        asm_d   = '0;
      end
      GATHER: if (pop) begin
        asm_d  = {asm_q[23:0], dout};
        need_d = need_q - 3'd1;
        // Capture the result on the final pop so data is valid alongside ack.
        if (need_q == 3'd1) begin
          state_d = DONE;
          data_d  = {asm_q[23:0], dout};
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q   <= IDLE;
      need_q    <= '0;
      asm_q     <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      need_q    <= need_d;
      asm_q     <= asm_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  assign bus.ack  = state_q == DONE;
  assign bus.data = data_q;
  assign overrun  = overrun_q;
`ifdef UART_RX_STATS_EN
  logic [15:0] rx_cnt_q, rx_cnt_d, drop_cnt_q, drop_cnt_d;
  always_comb begin
    rx_cnt_d   = rx_cnt_q + {15'd0, bus.rx_valid};
    drop_cnt_d = drop_cnt_q + {15'd0, drop};
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  assign rx_count   = rx_cnt_q;
  assign drop_count = drop_cnt_q;
`else
  assign rx_count   = '0;
  assign drop_count = '0;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl with directed stimulus.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 16;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic ovr_clr = 1'b0;
  logic [4:0] level;
  logic overrun;
  logic [15:0] rx_count, drop_count;
  uart_rx_ctrl_if bus();
  uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus), .ovr_clr(ovr_clr), .level(level),
    .overrun(overrun), .rx_count(rx_count), .drop_count(drop_count)
  );
  typedef struct {
    logic [31:0] data;
    int cyc;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int acks = 0;
  int cyc = 0;
  initial forever #5 CLK = ~CLK;
  initial forever begin
    @(posedge CLK);
    cyc++;
  end
  initial forever begin
    exp_t e;
    @(negedge CLK);
    if (bus.ack === 1'b1) begin
      acks++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected cyc=%0d data=%h", cyc, bus.data);
      end else begin
        e = q.pop_front();
        if (bus.data !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL ack_data got data=%h cyc=%0d expected data=%h cyc=%0d", bus.data, cyc, e.data, e.cyc);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d expected finish", cyc);
    $fatal(1);
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask
  task automatic expect_ack(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc = c;
    q.push_back(e);
  endtask
  task automatic push_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask
  task automatic wait_ack(input int n);
    int t = 0;
    while (acks < n && t < 100) begin
      tick();
      t++;
    end
    checks++;
    if (acks < n) begin
      errors++;
      $display("FAIL ack_timeout got %0d acks expected %0d", acks, n);
    end
  endtask
  task automatic read(input logic word, input logic [31:0] d);
    int n = acks + 1;
    bus.req = 1'b1;
    bus.req_word = word;
    expect_ack(d, cyc + (word ? 5 : 2));
    tick();
    bus.req = 1'b0;
    wait_ack(n);
  endtask
  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
  endtask
  initial begin
    int a0;
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    bus.req = 1'b0;
    bus.req_word = 1'b0;
    do_reset();
    chk("reset_level", 32'(level), 0);
    chk("reset_ack", 32'(bus.ack), 0);
    chk("reset_data", bus.data, 0);
    chk("reset_overrun", 32'(overrun), 0);
    push_byte(8'h12);
    push_byte(8'h34);
    push_byte(8'h56);
    push_byte(8'h78);
    chk("level_after_4", 32'(level), 4);
    read(1'b1, 32'h12345678);
    chk("level_after_word", 32'(level), 0);
    a0 = acks;
    bus.req = 1'b1;
    bus.req_word = 1'b0;
    repeat (10) tick();
    chk("no_ack_while_empty", 32'(acks), 32'(a0));
    expect_ack(32'h000000A5, cyc + 2);
    push_byte(8'hA5);
    tick();
    bus.req = 1'b0;
    repeat (5) tick();
    chk("byte_ack_once", 32'(acks), 32'(a0 + 1));
    do_reset();
    chk("reset2_data", bus.data, 0);
    for (int i = 0; i < 17; i++) push_byte(8'h20 + 8'(i));
    chk("full_level", 32'(level), 16);
    chk("overrun_set", 32'(overrun), 1);
`ifdef UART_RX_STATS_EN
    chk("rx_count", 32'(rx_count), 17);
    chk("drop_count", 32'(drop_count), 1);
`else
    chk("rx_count_tied", 32'(rx_count), 0);
    chk("drop_count_tied", 32'(drop_count), 0);
`endif
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("overrun_cleared", 32'(overrun), 0);
    a0 = acks;
    bus.req = 1'b1;
    bus.req_word = 1'b1;
    expect_ack(32'h20212223, cyc + 5);
    tick();
    bus.req = 1'b0;
    bus.rx_data = 8'h99;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    chk("push_pop_full_level", 32'(level), 16);
    chk("push_pop_full_overrun", 32'(overrun), 0);
    wait_ack(a0 + 1);
    chk("level_after_full_word", 32'(level), 13);
    read(1'b1, 32'h24252627);
    read(1'b1, 32'h28292A2B);
    read(1'b1, 32'h2C2D2E2F);
    read(1'b0, 32'h00000099);
    chk("level_drained", 32'(level), 0);
    push_byte(8'h41);
    push_byte(8'h42);
    a0 = acks;
    bus.req = 1'b1;
    bus.req_word = 1'b1;
    tick();
    bus.req = 1'b0;
    repeat (3) tick();
    RST_N = 1'b0;
    #1;
    chk("midreset_level", 32'(level), 0);
    chk("midreset_ack", 32'(bus.ack), 0);
    tick();
    RST_N = 1'b1;
    repeat (6) tick();
    chk("midreset_no_ack", 32'(acks), 32'(a0));
    push_byte(8'h55);
    read(1'b0, 32'h00000055);
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    a0 = acks;
    bus.req = 1'b1;
    bus.req_word = 1'b1;
    expect_ack(32'h01020304, cyc + 5);
    expect_ack(32'h05060708, cyc + 11);
    repeat (11) tick();
    bus.req = 1'b0;
    wait_ack(a0 + 2);
    repeat (8) tick();
    chk("back_to_back_acks", 32'(acks), 32'(a0 + 2));
    chk("final_level", 32'(level), 0);
    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
